axis_rate_limiter: RTL and testbench

Bandwidth limiter for an AXI4-Stream link. It passes stream beats unchanged from a slave port to a master port and throttles `s_axis_tready` so the long-term beat rate is at most `rate_num/rate_denom` of the clock rate. It can optionally throttle only between frames, so frames are never split. It sits inline between a stream source and a MAC/FIFO or any other AXI-Stream sink.

---
 rtl/axis_rate_limiter.sv | 205 ++++++++++++++++++++
 tb/tb_axis_rate_limiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rate_limiter.sv
// axis_rate_limiter
//
// Throttles an AXI4-Stream link to a long-term beat rate of at most
// rate_num/rate_denom beats per clock. Beats pass through unchanged via a
// two-entry registered skid buffer. When rate_by_frame is set, throttling is
// only applied between frames, so a frame is never split by a rate pause.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous reset, active low (0 = reset)
//   s_axis_*       input stream (tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser)
//   m_axis_*       output stream, same fields
//   rate_num       rate numerator (beats)
//   rate_denom     rate denominator (cycles)
//   rate_by_frame  1 = only pause at frame boundaries
//
// Disabled sideband fields: tkeep reads as all-ones, tlast as 1 (every beat is
// a frame), tid/tdest/tuser as 0.

module axis_rate_limiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int LAST_ENABLE = 1,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    input  logic [7:0]            rate_num,
    input  logic [7:0]            rate_denom,
    input  logic                  rate_by_frame
);

    // All beat fields travel together as one packed word.
    localparam int BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    logic [KEEP_WIDTH-1:0] in_keep;
    logic                  in_last;
    logic [ID_WIDTH-1:0]   in_id;
    logic [DEST_WIDTH-1:0] in_dest;
    logic [USER_WIDTH-1:0] in_user;

    // Disabled fields are forced to their fixed value; the input port is
    // still read so it does not appear dangling.
    generate
        if (KEEP_ENABLE != 0) begin : g_keep
            assign in_keep = s_axis_tkeep;
        end else begin : g_no_keep
            assign in_keep = {KEEP_WIDTH{1'b1}} | s_axis_tkeep;
        end
        if (LAST_ENABLE != 0) begin : g_last
            assign in_last = s_axis_tlast;
        end else begin : g_no_last
            assign in_last = 1'b1 | s_axis_tlast;
        end
        if (ID_ENABLE != 0) begin : g_id
            assign in_id = s_axis_tid;
        end else begin : g_no_id
            assign in_id = {ID_WIDTH{1'b0}} & s_axis_tid;
        end
        if (DEST_ENABLE != 0) begin : g_dest
            assign in_dest = s_axis_tdest;
        end else begin : g_no_dest
            assign in_dest = {DEST_WIDTH{1'b0}} & s_axis_tdest;
        end
        if (USER_ENABLE != 0) begin : g_user
            assign in_user = s_axis_tuser;
        end else begin : g_no_user
            assign in_user = {USER_WIDTH{1'b0}} & s_axis_tuser;
        end
    endgenerate

    logic [BEAT_WIDTH-1:0] in_beat;
    assign in_beat = {s_axis_tdata, in_keep, in_last, in_id, in_dest, in_user};

    // State
    logic [23:0]           acc_reg, acc_next;
    logic                  frame_reg, frame_next;
    logic                  s_ready_reg, s_ready_next;
    logic                  m_valid_reg, m_valid_next;
    logic                  temp_valid_reg, temp_valid_next;
    logic [BEAT_WIDTH-1:0] m_beat_reg, temp_beat_reg;

    // Skid-buffer control
    logic buf_ready_early;
    logic store_in_to_out;
    logic store_in_to_temp;
    logic store_temp_to_out;

    // Rate control
    logic        transfer_in;
    logic        pause;
    logic [23:0] num_ext;
    logic [23:0] denom_ext;
    logic [23:0] acc_inc;

    assign transfer_in = s_axis_tvalid && s_ready_reg;
    assign num_ext     = {16'd0, rate_num};
    assign denom_ext   = {16'd0, rate_denom};
    // Clamped at zero so rate_num >= rate_denom means full rate instead of
    // wrapping the accumulator to a huge value.
    assign acc_inc     = (rate_denom > rate_num) ? (denom_ext - num_ext) : 24'd0;

    always_comb begin
        m_valid_next      = m_valid_reg;
        temp_valid_next   = temp_valid_reg;
        store_in_to_out   = 1'b0;
        store_in_to_temp  = 1'b0;
        store_temp_to_out = 1'b0;

        // Buffer can take a beat next cycle if the output drains, or if the
        // temp slot is empty and at most one beat is held after this cycle.
        buf_ready_early = m_axis_tready || (!temp_valid_reg && (!m_valid_reg || !s_axis_tvalid));

        if (s_ready_reg) begin
            if (m_axis_tready || !m_valid_reg) begin
                m_valid_next    = s_axis_tvalid;
                store_in_to_out = 1'b1;
            end else begin
                // Beat arriving while tready was already committed high.
                temp_valid_next  = s_axis_tvalid;
                store_in_to_temp = 1'b1;
            end
        end else if (m_axis_tready) begin
            m_valid_next      = temp_valid_reg;
            temp_valid_next   = 1'b0;
            store_temp_to_out = 1'b1;
        end
    end

    always_comb begin
        acc_next   = acc_reg;
        frame_next = frame_reg;

        if (acc_reg >= num_ext) begin
            acc_next = acc_reg - num_ext;
        end

        // An accepted beat charges the accumulator instead of draining it.
        if (transfer_in) begin
            acc_next   = acc_reg + acc_inc;
            frame_next = !in_last;
        end

        pause        = (acc_next >= num_ext) && (!rate_by_frame || !frame_next);
        s_ready_next = buf_ready_early && !pause;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_reg        <= 24'd0;
            frame_reg      <= 1'b0;
            s_ready_reg    <= 1'b0;
            m_valid_reg    <= 1'b0;
            temp_valid_reg <= 1'b0;
            m_beat_reg     <= '0;
            temp_beat_reg  <= '0;
        end else begin
            acc_reg        <= acc_next;
            frame_reg      <= frame_next;
            s_ready_reg    <= s_ready_next;
            m_valid_reg    <= m_valid_next;
            temp_valid_reg <= temp_valid_next;

            if (store_in_to_out) begin
                m_beat_reg <= in_beat;
            end else if (store_temp_to_out) begin
                m_beat_reg <= temp_beat_reg;
            end

            if (store_in_to_temp) begin
                temp_beat_reg <= in_beat;
            end
        end
    end

    assign s_axis_tready = s_ready_reg;
    assign m_axis_tvalid = m_valid_reg;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = m_beat_reg;

endmodule

// File: tb/tb_axis_rate_limiter.sv
// Directed testbench for axis_rate_limiter with all sideband fields enabled.

module tb_axis_rate_limiter;

    localparam int DW  = 16;
    localparam int KW  = 2;
    localparam int IW  = 8;
    localparam int DSW = 8;
    localparam int UW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [DW-1:0]  s_axis_tdata;
    logic [KW-1:0]  s_axis_tkeep;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic           s_axis_tlast;
    logic [IW-1:0]  s_axis_tid;
    logic [DSW-1:0] s_axis_tdest;
    logic [UW-1:0]  s_axis_tuser;
    logic [DW-1:0]  m_axis_tdata;
    logic [KW-1:0]  m_axis_tkeep;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
    logic           m_axis_tlast;
    logic [IW-1:0]  m_axis_tid;
    logic [DSW-1:0] m_axis_tdest;
    logic [UW-1:0]  m_axis_tuser;
    logic [7:0]     rate_num;
    logic [7:0]     rate_denom;
    logic           rate_by_frame;

    axis_rate_limiter #(
        .DATA_WIDTH(DW), .KEEP_ENABLE(1), .KEEP_WIDTH(KW), .LAST_ENABLE(1),
        .ID_ENABLE(1), .ID_WIDTH(IW), .DEST_ENABLE(1), .DEST_WIDTH(DSW),
        .USER_ENABLE(1), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
        .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
        .rate_num(rate_num), .rate_denom(rate_denom), .rate_by_frame(rate_by_frame)
    );

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    typedef struct {
        int    cyc;
        beat_t b;
    } rec_t;

    beat_t s_beat, m_beat;
    assign s_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser};
    assign m_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser};

    rec_t in_q[$];
    rec_t out_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   stall_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output ready: 0 = low, 1 = high, 2 = pseudo-random.
    int          ready_mode = 1;
    logic [15:0] lfsr = 16'hACE1;
    always @(posedge clk) begin
        #2;
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        case (ready_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = lfsr[0];
        endcase
    end

    // Transfer monitor plus stall-stability check.
    logic  chk_stable = 1'b0;
    logic  stall_prev = 1'b0;
    beat_t stall_beat = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (s_axis_tvalid && s_axis_tready) in_q.push_back('{cyc: cyc, b: s_beat});
            if (m_axis_tvalid && m_axis_tready) out_q.push_back('{cyc: cyc, b: m_beat});
            if (chk_stable && stall_prev) begin
                stall_seen++;
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_beat", m_beat, stall_beat);
            end
            stall_prev <= m_axis_tvalid && !m_axis_tready;
            stall_beat <= m_beat;
        end else begin
            stall_prev <= 1'b0;
        end
    end

    function automatic beat_t exp_beat(input logic [15:0] base, input int i, input int flen);
        beat_t b;
        b.data = base + 16'(i);
        b.keep = 2'(i + 1);
        b.last = ((i % flen) == flen - 1);
        b.id   = base[15:8] ^ 8'(i);
        b.dest = 8'(i * 3 + 1);
        b.user = 4'(i ^ 5);
        return b;
    endfunction

    task automatic send(input string tag, input logic [15:0] base, input int n, input int flen, input int budget);
        int    i = 0;
        int    k = 0;
        logic  hs;
        beat_t b;
        while (i < n && k < budget) begin
            b = exp_beat(base, i, flen);
            s_axis_tvalid = 1'b1;
            {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser} = b;
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            if (hs) i++;
            k++;
        end
        s_axis_tvalid = 1'b0;
        check(tag, i, n);
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, out_q.size(), n);
    endtask

    task automatic check_stream(input string tag, input logic [15:0] base, input int n, input int flen);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= out_q.size() || out_q[i].b !== exp_beat(base, i, flen)) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic check_in_gaps(input string tag, input int gap);
        int bad = 0;
        for (int i = 1; i < in_q.size(); i++) begin
            if (in_q[i].cyc - in_q[i-1].cyc != gap) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        in_q.delete();
        out_q.delete();
    endtask

    int exp_gap[7] = '{1, 1, 1, 13, 1, 1, 1};
    int win;
    int rel;

    initial begin
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser} = '0;
        rate_num = 8'd1;
        rate_denom = 8'd1;
        rate_by_frame = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_axis_tvalid, 0);
        check("rst_s_ready", s_axis_tready, 0);
        check("rst_m_data", m_axis_tdata, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_s_ready", s_axis_tready, 1);

        // Full rate, one 8-beat frame
        idle(2);
        send("t1_sent", 16'h1000, 8, 8, 50);
        wait_out("t1_count", 8, 50);
        check_stream("t1_beats", 16'h1000, 8, 8);
        check("t1_latency", out_q[0].cyc - in_q[0].cyc, 1);
        check("t1_out_span", out_q[7].cyc - out_q[0].cyc, 7);

        // Rate 1/4, 16 single-beat frames
        rate_num = 8'd1;
        rate_denom = 8'd4;
        idle(20);
        send("t2_sent", 16'h2000, 16, 1, 200);
        wait_out("t2_count", 16, 50);
        check_stream("t2_beats", 16'h2000, 16, 1);
        check_in_gaps("t2_in_gap4", 4);
        check("t2_out_span", out_q[15].cyc - out_q[0].cyc, 60);

        // Rate 3/8, 64 beats
        rate_num = 8'd3;
        rate_denom = 8'd8;
        idle(20);
        send("t3_sent", 16'h3000, 64, 8, 400);
        wait_out("t3_count", 64, 50);
        check_stream("t3_beats", 16'h3000, 64, 8);
        win = 0;
        foreach (in_q[i]) if (in_q[i].cyc < in_q[0].cyc + 64) win++;
        check("t3_window", win, 24);

        // Rate 1/4 by frame: two 4-beat frames back-to-back, then drained gap
        rate_num = 8'd1;
        rate_denom = 8'd4;
        rate_by_frame = 1'b1;
        idle(20);
        send("t4f_sent", 16'h4000, 8, 4, 100);
        wait_out("t4f_count", 8, 50);
        check_stream("t4f_beats", 16'h4000, 8, 4);
        for (int i = 0; i < 7; i++) check("t4f_gap", in_q[i+1].cyc - in_q[i].cyc, exp_gap[i]);

        // Same frames without frame mode: split 1-in-4
        rate_by_frame = 1'b0;
        idle(20);
        send("t4b_sent", 16'h4100, 8, 4, 100);
        wait_out("t4b_count", 8, 50);
        check_stream("t4b_beats", 16'h4100, 8, 4);
        check_in_gaps("t4b_in_gap4", 4);

        // Full rate with random output backpressure
        rate_num = 8'd1;
        rate_denom = 8'd1;
        idle(20);
        chk_stable = 1'b1;
        ready_mode = 2;
        send("t5_sent", 16'h5000, 32, 8, 500);
        wait_out("t5_count", 32, 500);
        chk_stable = 1'b0;
        ready_mode = 1;
        check_stream("t5_beats", 16'h5000, 32, 8);
        check("t5_stalls_seen", stall_seen > 0, 1);

        // Reset mid-frame with beats held in the buffer
        rate_num = 8'd1;
        rate_denom = 8'd4;
        rate_by_frame = 1'b1;
        ready_mode = 0;
        idle(20);
        send("t6_pre_sent", 16'h6000, 2, 8, 20);
        check("t6_pre_valid", m_axis_tvalid, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_m_valid", m_axis_tvalid, 0);
        check("t6_rst_s_ready", s_axis_tready, 0);
        rst = 1'b1;
        rel = cyc;
        in_q.delete();
        out_q.delete();
        ready_mode = 1;
        send("t6_sent", 16'h6100, 4, 4, 50);
        wait_out("t6_count", 4, 50);
        check_stream("t6_beats", 16'h6100, 4, 4);
        check("t6_first_in", in_q[0].cyc - rel, 1);
        check_in_gaps("t6_in_gap1", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
